// File: rtl/fpga_oser10_ctrl.sv
// Sequencer for a bank of 10:1 output serializers: holds the serializer reset,
// trains with an idle word, then streams source words with idle fill on underflow.
module fpga_oser10_ctrl #(
    parameter int          NLANES       = 3,
    parameter int          RST_CYCLES   = 8,
    parameter int          TRAIN_CYCLES = 64,
    parameter logic [9:0]  IDLE_WORD    = 10'b1101010100,
    parameter logic [9:0]  CLK_WORD     = 10'b1111100000
) (
    input  logic                   clk_par,
    input  logic                   arst,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NLANES*10-1:0]   s_data,
    input  logic                   underflow_clr,
    output logic                   oser_rst,
    output logic [NLANES*10-1:0]   lane_d,
    output logic [9:0]             clk_d,
    output logic [1:0]             state,
    output logic                   active,
    output logic [15:0]            underflow_cnt
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_RST   = 2'd1;
    localparam logic [1:0] ST_TRAIN = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam int MAXC = (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]          RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]          TRAIN_LAST = CW'(TRAIN_CYCLES - 1);
    localparam logic [NLANES*10-1:0]   IDLE_ALL   = {NLANES{IDLE_WORD}};

    logic [CW-1:0] phase_cnt;
    logic [CW-1:0] phase_next;
    logic [1:0]    state_next;
    logic          accept;
    logic          underflow;

    assign s_ready   = (state == ST_RUN);
    assign accept    = s_ready && s_valid;
    assign underflow = s_ready && !s_valid;

    // Dropping en overrides any in-progress count or transition.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        case (state)
            ST_OFF: begin
                if (en) begin
                    state_next = ST_RST;
                    phase_next = '0;
                end
            end
            ST_RST: begin
                if (phase_cnt == RST_LAST) begin
                    state_next = ST_TRAIN;
                    phase_next = '0;
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end
            ST_TRAIN: begin
                if (phase_cnt == TRAIN_LAST) begin
                    state_next = ST_RUN;
                    phase_next = '0;
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (!en) begin
            state_next = ST_OFF;
            phase_next = '0;
        end
    end

    // Serializer controls are registered from next-state so they move with state.
    always_ff @(posedge clk_par or posedge arst) begin
        if (arst) begin
            state     <= ST_OFF;
            phase_cnt <= '0;
            oser_rst  <= 1'b1;
            lane_d    <= IDLE_ALL;
            clk_d     <= '0;
            active    <= 1'b0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            oser_rst  <= (state_next == ST_OFF) || (state_next == ST_RST);
            clk_d     <= (state_next == ST_OFF) ? 10'd0 : CLK_WORD;
            active    <= (state_next == ST_RUN);
            lane_d    <= accept ? s_data : IDLE_ALL;
        end
    end

    // Clear wins over a same-cycle increment; the count survives en toggling.
    always_ff @(posedge clk_par or posedge arst) begin
        if (arst) begin
            underflow_cnt <= '0;
        end else if (underflow_clr) begin
            underflow_cnt <= '0;
        end else if (underflow && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule
